param_register_bank: RTL and testbench

PARAM_REGISTER_BANK -- requirements
Module: param_register_bank

---
 rtl/param_register_bank.sv | 172 +++++++++++++++++
 tb/tb_param_register_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_bank.sv
// param_register_bank: NREG x WIDTH register file with single-cycle load/arithmetic
// operations and multi-cycle one-bit-per-edge shifts (LSL, LSR, ASR, optional ROL).
// Optional feature macro: REGBANK_ROTATE_EN enables code 1011 as rotate-left;
// without it, 1011 is a reserved no-op and no rotate path is built.
module param_register_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         I,
    input  logic [3:0]               FunSel,
    input  logic [NREG-1:0]          RegSel,
    input  logic                     Start,
    input  logic [$clog2(WIDTH)-1:0] ShAmt,
    input  logic [$clog2(NREG)-1:0]  OutASel,
    input  logic [$clog2(NREG)-1:0]  OutBSel,
    output logic [WIDTH-1:0]         OutA,
    output logic [WIDTH-1:0]         OutB,
    output logic                     Busy,
    output logic                     Done
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(NREG);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q;
    logic [SW-1:0]     cnt_q;
    logic [1:0]        fun_q;
    logic [NREG-1:0]   sel_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  regs_q [NREG];
    logic [WIDTH-1:0]  regs_d [NREG];

    logic              accept;
    logic              shift_code;
    logic              enter_shift;

    // Single-cycle operations, indexed by the low three bits of a 0xxx code.
    function automatic logic [WIDTH-1:0] load_op(input logic [2:0]       f,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = q;
        unique case (f)
            3'b000: r = q - WIDTH'(1);
            3'b001: r = q + WIDTH'(1);
            3'b010: r = d;
            3'b011: r = '0;
            3'b100: r = {{(WIDTH-8){1'b0}}, d[7:0]};
            3'b101: r = {{(WIDTH-16){1'b0}}, d[15:0]};
            3'b110: r = {q[WIDTH-9:0], d[7:0]};
            3'b111: r = {{(WIDTH-16){d[15]}}, d[15:0]};
            default: r = q;
        endcase
        return r;
    endfunction

    // One-bit shift step for the latched shift code.
    function automatic logic [WIDTH-1:0] shift_one(input logic [1:0]       f,
                                                   input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] r;
        r = q;
        unique case (f)
            2'b00: r = {q[WIDTH-2:0], 1'b0};
            2'b01: r = {1'b0, q[WIDTH-1:1]};
            2'b10: r = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef REGBANK_ROTATE_EN
            2'b11: r = {q[WIDTH-2:0], q[WIDTH-1]};
`else
            2'b11: r = q;
`endif
            default: r = q;
        endcase
        return r;
    endfunction

`ifdef REGBANK_ROTATE_EN
    assign shift_code = (FunSel[3:2] == 2'b10);
`else
    assign shift_code = (FunSel[3:2] == 2'b10) && (FunSel[1:0] != 2'b11);
`endif

    assign accept      = Start && !busy_q;
    assign enter_shift = accept && shift_code && (ShAmt != '0);

    // Next register values: single-cycle ops on accept, one shift step per SHIFT edge.
    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            regs_d[k] = regs_q[k];
            if (state_q == StIdle) begin
                if (accept && !FunSel[3] && RegSel[k]) begin
                    regs_d[k] = load_op(FunSel[2:0], regs_q[k], I);
                end
            end else if (sel_q[k]) begin
                regs_d[k] = shift_one(fun_q, regs_q[k]);
            end
        end
    end

    // Register file storage.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Command FSM with registered Busy/Done; shift operands are latched on entry.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fun_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enter_shift) begin
                        state_q <= StShift;
                        cnt_q   <= ShAmt;
                        fun_q   <= FunSel[1:0];
                        sel_q   <= RegSel;
                        busy_q  <= 1'b1;
                    end else if (accept) begin
                        done_q  <= 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q == SW'(1)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - SW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read ports; selects beyond the last register read zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NREG; k++) begin
            if (OutASel == RW'(k)) OutA = regs_q[k];
            if (OutBSel == RW'(k)) OutB = regs_q[k];
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_param_register_bank.sv
// Scoreboard bench for param_register_bank (WIDTH=32, NREG=4): the stimulus process
// queues the expected register file and Done cycle of each command; the monitor pops
// and compares whenever Done is seen.
module tb_param_register_bank;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 5;
    localparam int RW = 2;

    logic          Clock;
    logic          Reset;
    logic [W-1:0]  I;
    logic [3:0]    FunSel;
    logic [N-1:0]  RegSel;
    logic          Start;
    logic [SW-1:0] ShAmt;
    logic [RW-1:0] OutASel;
    logic [RW-1:0] OutBSel;
    logic [W-1:0]  OutA;
    logic [W-1:0]  OutB;
    logic          Busy;
    logic          Done;

    param_register_bank #(.WIDTH(W), .NREG(N)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .Start   (Start),
        .ShAmt   (ShAmt),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB),
        .Busy    (Busy),
        .Done    (Done)
    );

    typedef struct packed {
        logic [N-1:0][W-1:0] regs;
        int                  cyc;
    } exp_t;

    exp_t                sb[$];
    logic [N-1:0][W-1:0] model;
    int                  cyc;
    int                  compared;
    int                  mismatched;

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic read_b(input int k, output logic [W-1:0] v);
        OutBSel = RW'(k);
        #1;
        v = OutB;
    endtask

    // Reference behaviour: whole shift applied at once; returns extra busy cycles.
    task automatic model_apply(input logic [3:0] f, input logic [N-1:0] s,
                               input logic [W-1:0] d, input int n, output int lat);
        logic [W-1:0] x;
        lat = 0;
        if (f[3:2] == 2'b10 && n > 0) begin
`ifdef REGBANK_ROTATE_EN
            lat = n;
`else
            if (f != 4'b1011) lat = n;
`endif
        end
        for (int k = 0; k < N; k++) begin
            x = model[k];
            if (s[k]) begin
                case (f)
                    4'b0000: x = x - 1;
                    4'b0001: x = x + 1;
                    4'b0010: x = d;
                    4'b0011: x = 0;
                    4'b0100: x = d & 32'h0000_00FF;
                    4'b0101: x = d & 32'h0000_FFFF;
                    4'b0110: x = (x << 8) | (d & 32'h0000_00FF);
                    4'b0111: x = d[15] ? (d | 32'hFFFF_0000) : (d & 32'h0000_FFFF);
                    4'b1000: x = x << n;
                    4'b1001: x = x >> n;
                    4'b1010: x = W'($signed(x) >>> n);
`ifdef REGBANK_ROTATE_EN
                    4'b1011: if (n > 0) x = (x << n) | (x >> (W - n));
`endif
                    default: x = x;
                endcase
            end
            model[k] = x;
        end
    endtask

    // Drive one command, queue its expectation, then scramble inputs while busy.
    task automatic issue(input logic [3:0] f, input logic [N-1:0] s,
                         input logic [W-1:0] d, input int n);
        exp_t e;
        int   lat;
        model_apply(f, s, d, n, lat);
        e.regs = model;
        e.cyc  = cyc + 1 + lat;
        sb.push_back(e);
        FunSel = f;
        RegSel = s;
        I      = d;
        ShAmt  = SW'(n);
        Start  = 1'b1;
        for (int j = 1; j <= lat; j++) begin
            @(negedge Clock);
            check("busy_during_shift", Busy, 1'b1);
            if (j == 1) begin
                Start  = 1'b1;
                FunSel = 4'b0011;
                RegSel = '1;
            end else begin
                Start  = 1'($urandom_range(0, 1));
                FunSel = 4'($urandom);
                RegSel = N'($urandom);
            end
            I     = $urandom;
            ShAmt = SW'($urandom);
        end
        @(negedge Clock);
        check("busy_clear", Busy, 1'b0);
        Start = 1'b0;
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        OutASel = '0;
        forever begin
            @(negedge Clock);
            if (Reset === 1'b1 && Done === 1'b1) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got Done=1 expected no pending command (t=%0t)",
                             $time);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    for (int k = 0; k < N; k++) begin
                        OutASel = RW'(k);
                        #1;
                        check($sformatf("R%0d", k), OutA, e.regs[k]);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        int           n;
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        model      = '0;
        Reset      = 1'b0;
        Start      = 1'b0;
        I          = '0;
        FunSel     = '0;
        RegSel     = '0;
        ShAmt      = '0;
        OutBSel    = '0;

        repeat (2) @(negedge Clock);
        check("reset_busy", Busy, 1'b0);
        check("reset_done", Done, 1'b0);
        for (int k = 0; k < N; k++) begin
            read_b(k, v);
            check($sformatf("reset_R%0d", k), v, 0);
        end
        @(negedge Clock);
        Reset = 1'b1;

        // Load with a multi-hot mask, accepted on the first edge after reset.
        issue(4'b0010, 4'b0101, 32'hDEAD_BEEF, 0);

        // Wrap in both directions.
        issue(4'b0010, 4'b0010, 32'hFFFF_FFFF, 0);
        issue(4'b0001, 4'b0010, 32'h0, 0);
        read_b(1, v);
        check("wrap_inc", v, 32'h0000_0000);
        issue(4'b0000, 4'b0010, 32'h0, 0);
        read_b(1, v);
        check("wrap_dec", v, 32'hFFFF_FFFF);

        // ASR by 4 with a clear attempted while busy.
        issue(4'b0010, 4'b0001, 32'h8000_0001, 0);
        issue(4'b1010, 4'b0001, 32'h0, 4);
        read_b(0, v);
        check("asr4", v, 32'hF800_0000);

        // Byte shift-in and sign extension.
        issue(4'b0010, 4'b1000, 32'h1122_3344, 0);
        issue(4'b0110, 4'b1000, 32'h0000_00AB, 0);
        read_b(3, v);
        check("byte_shift", v, 32'h2233_44AB);
        issue(4'b0111, 4'b1000, 32'h0000_8001, 0);
        read_b(3, v);
        check("sign_ext", v, 32'hFFFF_8001);

        // Rotate (or reserved no-op) by 1.
        issue(4'b0010, 4'b0100, 32'h8000_0001, 0);
        issue(4'b1011, 4'b0100, 32'h0, 1);
        read_b(2, v);
`ifdef REGBANK_ROTATE_EN
        check("rol1", v, 32'h0000_0003);
`else
        check("rol1_noop", v, 32'h8000_0001);
`endif

        // Zero mask, zero shift amount, reserved codes still complete.
        issue(4'b0001, 4'b0000, 32'h0, 0);
        issue(4'b1000, 4'b1111, 32'h0, 0);
        issue(4'b1110, 4'b1111, 32'h0, 0);

        // Reset asserted after two shift edges of a six-bit shift.
        issue(4'b0010, 4'b1111, 32'h0000_00F0, 0);
        FunSel = 4'b1000;
        RegSel = 4'b1111;
        ShAmt  = SW'(6);
        Start  = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("midreset_busy", Busy, 1'b0);
        check("midreset_done", Done, 1'b0);
        for (int k = 0; k < N; k++) begin
            read_b(k, v);
            check($sformatf("midreset_R%0d", k), v, 0);
        end
        model = '0;
        @(negedge Clock);
        Reset = 1'b1;
        issue(4'b0010, 4'b0011, 32'h1234_5678, 0);

        // Randomized commands, back to back.
        for (int t = 0; t < 200; t++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(0, 5));
            issue(4'($urandom), N'($urandom), $urandom, n);
        end

        repeat (3) @(negedge Clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
